demux_1_8: RTL and testbench
============================

DEMUX_1_8 -- requirements
Module: demux_1_8

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. Ports, in order, SHALL be:
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 d_in  input  1  serial data bit.
REQ-005 d_valid  input  1  d_in (and sel, in addressed mode) are valid this cycle.
REQ-006 in_ready  output  1  block can accept a bit this cycle.
REQ-007 sel  input  3  destination bit index, used only in addressed mode.
REQ-008 mode  input  1  0 = addressed (use sel); 1 = sequential (internal pointer).
REQ-009 o  output  8  registered demultiplexed byte.
REQ-010 o_valid  output  1  o holds a complete byte.
REQ-011 o_ready  input  1  downstream consumes o when o_valid=1.
REQ-012 dup_err  output  1  one-cycle pulse: addressed write to an already-written bit.

Function
REQ-013 State machine SHALL have two states: COLLECT (assembling a byte) and HOLD (byte complete, waiting for consumption).
REQ-014 A bit SHALL be accepted in a cycle iff d_valid=1 and in_ready=1; in_ready SHALL equal 1 in COLLECT and 0 in HOLD (no same-cycle bypass).
REQ-015 Internal state SHALL comprise an 8-bit written mask, a 3-bit pointer ptr, and a 1-bit registered copy of mode (mode_q).
REQ-016 In addressed mode, an accepted bit SHALL update o[sel] <= d_in on the same clock edge; all other o bits SHALL hold, and mask[sel] SHALL be set.
REQ-017 In sequential mode, an accepted bit SHALL update o[ptr] <= d_in and set mask[ptr]; ptr SHALL increment by 1 modulo 8.
REQ-018 An accepted addressed write with mask[sel] already set SHALL overwrite o[sel] and pulse dup_err for exactly the cycle after acceptance; dup_err SHALL never assert in sequential mode.
REQ-019 When the accepted bit makes mask == 8'hFF, the FSM SHALL enter HOLD and assert o_valid on the next cycle (latency: one clock from the last bit's edge to o_valid visible).
REQ-020 In HOLD, o and o_valid SHALL be stable until o_ready=1 is sampled; on that edge the FSM SHALL return to COLLECT with o_valid=0, mask=0, and ptr=0.
REQ-021 o SHALL retain the consumed byte after the handshake until each bit is individually overwritten.
REQ-022 o_ready while o_valid=0 SHALL have no effect.
REQ-023 mode SHALL be sampled every cycle into mode_q; in COLLECT, a change of mode (mode != mode_q) SHALL abort the partial frame: mask=0, ptr=0, any bit offered that cycle SHALL be discarded, and o SHALL hold.
REQ-024 A mode change during HOLD SHALL NOT affect the held byte; the new mode SHALL apply after the handshake.
REQ-025 Back-to-back frames SHALL be supported: the first bit of the next frame SHALL be acceptable in the cycle after the o_valid/o_ready handshake.

Reset
REQ-026 On rst_n=0, regardless of clk, the block SHALL force: state=COLLECT, o=8'h00, o_valid=0, dup_err=0, mask=0, ptr=0, mode_q=0.
REQ-027 Outputs SHALL take their reset values immediately while rst_n=0; a partial frame or held byte SHALL be lost.
REQ-028 The first bit after reset deassertion SHALL be acceptable on the first rising clk edge with rst_n=1.

Verification
REQ-029 Sequential mode, eight back-to-back bits LSB-first 1,0,1,0,0,1,0,1 with o_ready=0 -> o=8'hA5, o_valid=1 one cycle after the 8th bit, in_ready=0; then o_ready=1 for one cycle -> o_valid=0, in_ready=1 next cycle.
REQ-030 Addressed mode, sel=7..0 descending with d_in=1 on even sel and 0 on odd sel -> o=8'h55, o_valid=1, dup_err never asserted.
REQ-031 Addressed mode, write sel=3 twice (d_in=0 then 1) followed by the remaining 7 indices with d_in=0 -> dup_err pulses once, and the final o=8'h08.
REQ-032 Sequential mode, 4 bits accepted, then mode switched to 1->0 with d_valid=1 -> that bit is dropped; 8 addressed writes are then needed for o_valid, and ptr restarts at 0 on return to sequential mode.
REQ-033 In HOLD with o=8'hA5, drive d_valid=1 with o_ready=0 for 5 cycles -> o stays 8'hA5 and no bit is accepted; drive rst_n low mid-frame -> o=8'h00 and o_valid=0 asynchronously.

Source files
------------

// File: rtl/demux_1_8.sv
// demux_1_8: serial bit to byte demultiplexer with addressed/sequential modes.
// Holds a completed byte until the downstream handshake.
module demux_1_8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       d_in,
    input  logic       d_valid,
    output logic       in_ready,
    input  logic [2:0] sel,
    input  logic       mode,
    output logic [7:0] o,
    output logic       o_valid,
    input  logic       o_ready,
    output logic       dup_err
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] mask;
    logic [2:0] ptr;
    logic       mode_q;

    logic       abort;
    logic       accept;
    logic [2:0] idx;
    logic [7:0] mask_nxt;

    assign in_ready = (state == COLLECT);
    assign abort    = in_ready && (mode != mode_q);
    assign accept   = in_ready && d_valid && !abort;
    assign idx      = mode ? ptr : sel;
    assign mask_nxt = mask | (8'h01 << idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COLLECT;
            o       <= 8'h00;
            o_valid <= 1'b0;
            dup_err <= 1'b0;
            mask    <= 8'h00;
            ptr     <= 3'd0;
            mode_q  <= 1'b0;
        end else begin
            mode_q  <= mode;
            dup_err <= accept && !mode && mask[idx];
            unique case (state)
                COLLECT: begin
                    // A mode flip drops the partial frame and the offered bit.
                    if (abort) begin
                        mask <= 8'h00;
                        ptr  <= 3'd0;
                    end else if (accept) begin
                        o[idx] <= d_in;
                        mask   <= mask_nxt;
                        if (mode)
                            ptr <= ptr + 3'd1;
                        if (mask_nxt == 8'hFF) begin
                            state   <= HOLD;
                            o_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (o_ready) begin
                        state   <= COLLECT;
                        o_valid <= 1'b0;
                        mask    <= 8'h00;
                        ptr     <= 3'd0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_1_8.sv
// tb_demux_1_8: table-driven frames with an expected-byte scoreboard,
// plus hand sequences for abort, hold stability and async reset.
module tb_demux_1_8;

    logic       clk;
    logic       rst_n;
    logic       d_in;
    logic       d_valid;
    logic       in_ready;
    logic [2:0] sel;
    logic       mode;
    logic [7:0] o;
    logic       o_valid;
    logic       o_ready;
    logic       dup_err;

    int checks = 0;
    int errors = 0;
    logic cur_mode;
    logic [7:0] sb[$];

    demux_1_8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_in    (d_in),
        .d_valid (d_valid),
        .in_ready(in_ready),
        .sel     (sel),
        .mode    (mode),
        .o       (o),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .dup_err (dup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m;
        int          n;
        logic [29:0] sels;
        logic [9:0]  ds;
        logic [7:0]  exp;
        int          dups;
    } frame_t;

    frame_t frames[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic m);
        if (m != cur_mode) begin
            mode    = m;
            d_valid = 1'b0;
            step();
            cur_mode = m;
        end
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!o_valid && k < 4) begin
            step();
            k++;
        end
        chk({name, "_latency"}, k, 0);
    endtask

    task automatic pop_cmp(input string name);
        logic [7:0] e;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({name, "_o"}, o, e);
            chk({name, "_in_ready_hold"}, in_ready, 0);
        end
    endtask

    task automatic handshake(input string name, input logic [7:0] keep);
        o_ready = 1'b1;
        step();
        o_ready = 1'b0;
        chk({name, "_hs_valid"}, o_valid, 0);
        chk({name, "_hs_ready"}, in_ready, 1);
        chk({name, "_hs_keep"}, o, keep);
        chk({name, "_hs_dup"}, dup_err, 0);
    endtask

    task automatic run_frame(input frame_t f, input string name);
        int dups;
        set_mode(f.m);
        sb.push_back(f.exp);
        dups = 0;
        for (int i = 0; i < f.n; i++) begin
            d_valid = 1'b1;
            sel     = f.sels[i*3+:3];
            d_in    = f.ds[i];
            step();
            if (dup_err) dups++;
            if (i < f.n - 1)
                chk({name, "_early_valid"}, o_valid, 0);
        end
        d_valid = 1'b0;
        wait_valid(name);
        pop_cmp(name);
        chk({name, "_dups"}, dups, f.dups);
        handshake(name, f.exp);
    endtask

    task automatic seq_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            d_valid = 1'b1;
            d_in    = b[i];
            step();
        end
        d_valid = 1'b0;
    endtask

    initial begin
        frames[0] = '{1'b0, 8,
                      30'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}),
                      10'b0010101010, 8'h55, 0};
        frames[1] = '{1'b0, 9,
                      30'({3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7,
                           3'd3, 3'd3}),
                      10'b0000000010, 8'h08, 1};
        frames[2] = '{1'b0, 8,
                      30'({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}),
                      10'h096, 8'h96, 0};
        frames[3] = '{1'b1, 8, 30'd0, 10'h0A5, 8'hA5, 0};
        frames[4] = '{1'b1, 8, 30'd0, 10'h03C, 8'h3C, 0};

        rst_n    = 1'b0;
        d_in     = 1'b0;
        d_valid  = 1'b0;
        sel      = 3'd0;
        mode     = 1'b0;
        o_ready  = 1'b0;
        cur_mode = 1'b0;
        #12;
        chk("rst_o", o, 8'h00);
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_dup", dup_err, 0);
        step();
        rst_n = 1'b1;

        for (int f = 0; f < 5; f++)
            run_frame(frames[f], $sformatf("frame%0d", f));

        // Hold stability: bits offered while the byte waits are ignored.
        sb.push_back(8'hA5);
        seq_bits(8'hA5, 8);
        wait_valid("hold");
        for (int i = 0; i < 5; i++) begin
            d_valid = 1'b1;
            d_in    = 1'b0;
            step();
            chk("hold_o", o, 8'hA5);
            chk("hold_valid", o_valid, 1);
        end
        d_valid = 1'b0;
        pop_cmp("hold");
        handshake("hold", 8'hA5);

        // Abort: four seq bits, then a mode flip with a bit offered.
        seq_bits(8'h0F, 4);
        mode    = 1'b0;
        d_valid = 1'b1;
        sel     = 3'd4;
        d_in    = 1'b1;
        step();
        cur_mode = 1'b0;
        chk("abort_drop", o, 8'hAF);
        for (int i = 1; i < 8; i++) begin
            sel  = 3'(i);
            d_in = 1'b0;
            step();
            chk("abort_dup", dup_err, 0);
        end
        d_valid = 1'b0;
        chk("abort_not_done", o_valid, 0);
        sb.push_back(8'h00);
        d_valid = 1'b1;
        sel     = 3'd0;
        d_in    = 1'b0;
        step();
        d_valid = 1'b0;
        chk("abort_dup8", dup_err, 0);
        wait_valid("abort");
        pop_cmp("abort");
        handshake("abort", 8'h00);

        // Back to sequential: flip cycle drops its bit, ptr restarts at 0.
        mode    = 1'b1;
        d_valid = 1'b1;
        d_in    = 1'b1;
        step();
        cur_mode = 1'b1;
        chk("flip_drop", o, 8'h00);
        sb.push_back(8'h01);
        seq_bits(8'h01, 8);
        wait_valid("ptr0");
        pop_cmp("ptr0");

        // Asynchronous reset while a byte is held.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_o", o, 8'h00);
        chk("arst_valid", o_valid, 0);
        chk("arst_ready", in_ready, 1);
        step();
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
